// File: rtl/svm_axil_regs.sv
// svm_axil_regs: AXI4-Lite register front-end for the SVM digit classifier.
// Register map (addr[3:2]; addr[1:0] ignored):
//   0x0 CTRL   RW  bit0 = start (drives start_o)
//   0x4 STATUS RO  bit0 = ready_i (live), bit1 = done (sticky)
//   0x8 RESULT RO  bits[3:0] = res_i latched on a ready_i rising edge
//   0xC STATE  RO  bits[3:0] = state_i (live)
// Ports:
//   s_axi_aclk / s_axi_areset : clock, synchronous active-high reset
//   s_axi_aw*, s_axi_w*, s_axi_b* : write address / data / response channels
//   s_axi_ar*, s_axi_r*           : read address / data channels
//   start_o : classifier start (CTRL[0]);  ready_i, res_i, state_i : classifier status
module svm_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            s_axi_aclk,
  input  logic                            s_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                      s_axi_awprot,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                      s_axi_arprot,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic                            start_o,
  input  logic                            ready_i,
  input  logic [3:0]                      res_i,
  input  logic [3:0]                      state_i
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Write-side holding registers (only the bits the map actually uses)
  logic       aw_held_r, w_held_r;
  logic [1:0] aw_addr_r;
  logic       w_data0_r, w_strb0_r;
  logic       awready_r, wready_r, bvalid_r;
  logic [1:0] bresp_r;
  // Read side
  logic                          arready_r, rvalid_r;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_r;
  logic [1:0]                    rresp_r;
  // Register file and classifier tracking
  logic       ctrl_r, done_r, ready_prev_r;
  logic [3:0] result_r;

  logic aw_hs_s, w_hs_s, ar_hs_s, write_fire_s, ready_rise_s, rd_result_s;
  logic aw_held_nxt_s, w_held_nxt_s, bvalid_nxt_s, rvalid_nxt_s, done_nxt_s;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_mux_s;
  logic unused_s;

  // Handshakes, next-state of the channel flags and the read-data mux
  always_comb begin
    aw_hs_s       = s_axi_awvalid && awready_r;
    w_hs_s        = s_axi_wvalid && wready_r;
    ar_hs_s       = s_axi_arvalid && arready_r;
    write_fire_s  = aw_held_r && w_held_r;
    ready_rise_s  = ready_i && !ready_prev_r;
    rd_result_s   = ar_hs_s && (s_axi_araddr[3:2] == 2'd2);
    aw_held_nxt_s = aw_held_r;
    w_held_nxt_s  = w_held_r;
    bvalid_nxt_s  = bvalid_r;
    rvalid_nxt_s  = rvalid_r;
    done_nxt_s    = done_r;
    rd_mux_s      = {C_S_AXI_DATA_WIDTH{1'b0}};

    // A completing write empties both holders; acceptance is impossible then
    // because both readies are low while anything is held.
    if (write_fire_s) begin
      aw_held_nxt_s = 1'b0;
      w_held_nxt_s  = 1'b0;
    end else begin
      if (aw_hs_s) aw_held_nxt_s = 1'b1;
      else         aw_held_nxt_s = aw_held_r;
      if (w_hs_s)  w_held_nxt_s  = 1'b1;
      else         w_held_nxt_s  = w_held_r;
    end

    if (write_fire_s)                bvalid_nxt_s = 1'b1;
    else if (bvalid_r && s_axi_bready) bvalid_nxt_s = 1'b0;
    else                             bvalid_nxt_s = bvalid_r;

    if (ar_hs_s)                      rvalid_nxt_s = 1'b1;
    else if (rvalid_r && s_axi_rready) rvalid_nxt_s = 1'b0;
    else                              rvalid_nxt_s = rvalid_r;

    // A fresh result beats a concurrent RESULT read clearing done
    if (ready_rise_s)     done_nxt_s = 1'b1;
    else if (rd_result_s) done_nxt_s = 1'b0;
    else                  done_nxt_s = done_r;

    case (s_axi_araddr[3:2])
      2'd0:    rd_mux_s[0]   = ctrl_r;
      2'd1:    rd_mux_s[1:0] = {done_r, ready_i};
      2'd2:    rd_mux_s[3:0] = result_r;
      2'd3:    rd_mux_s[3:0] = state_i;
      default: rd_mux_s      = {C_S_AXI_DATA_WIDTH{1'b0}};
    endcase
  end

  // Channel state, register file and registered AXI outputs
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      aw_held_r    <= 1'b0;
      w_held_r     <= 1'b0;
      aw_addr_r    <= 2'd0;
      w_data0_r    <= 1'b0;
      w_strb0_r    <= 1'b0;
      awready_r    <= 1'b0;
      wready_r     <= 1'b0;
      bvalid_r     <= 1'b0;
      bresp_r      <= RESP_OKAY;
      arready_r    <= 1'b0;
      rvalid_r     <= 1'b0;
      rdata_r      <= {C_S_AXI_DATA_WIDTH{1'b0}};
      rresp_r      <= RESP_OKAY;
      ctrl_r       <= 1'b0;
      result_r     <= 4'd0;
      done_r       <= 1'b0;
      ready_prev_r <= 1'b0;
    end else begin
      aw_held_r    <= aw_held_nxt_s;
      w_held_r     <= w_held_nxt_s;
      bvalid_r     <= bvalid_nxt_s;
      rvalid_r     <= rvalid_nxt_s;
      done_r       <= done_nxt_s;
      ready_prev_r <= ready_i;
      rresp_r      <= RESP_OKAY;
      // Readies are registered copies of their combinational definitions
      awready_r    <= !aw_held_nxt_s && !bvalid_nxt_s;
      wready_r     <= !w_held_nxt_s && !bvalid_nxt_s;
      arready_r    <= !rvalid_nxt_s;
      if (aw_hs_s) aw_addr_r <= s_axi_awaddr[3:2];
      if (w_hs_s) begin
        w_data0_r <= s_axi_wdata[0];
        w_strb0_r <= s_axi_wstrb[0];
      end
      if (write_fire_s) begin
        if (aw_addr_r == 2'd0) begin
          bresp_r <= RESP_OKAY;
          if (w_strb0_r) ctrl_r <= w_data0_r;
        end else begin
          bresp_r <= RESP_SLVERR;
        end
      end
      if (ar_hs_s) rdata_r <= rd_mux_s;
      if (ready_rise_s) result_r <= res_i;
    end
  end

  assign s_axi_awready = awready_r;
  assign s_axi_wready  = wready_r;
  assign s_axi_bvalid  = bvalid_r;
  assign s_axi_bresp   = bresp_r;
  assign s_axi_arready = arready_r;
  assign s_axi_rvalid  = rvalid_r;
  assign s_axi_rdata   = rdata_r;
  assign s_axi_rresp   = rresp_r;
  assign start_o       = ctrl_r;

  // Inputs that carry no meaning for this register map
  assign unused_s = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0],
                      s_axi_wdata[C_S_AXI_DATA_WIDTH-1:1], s_axi_wstrb[C_S_AXI_DATA_WIDTH/8-1:1]};

endmodule

// File: tb/tb_svm_axil_regs.sv
// Self-checking bench for svm_axil_regs: expected responses are pushed to
// queues when a transaction is accepted and popped when the DUT responds.
module tb_svm_axil_regs;
  logic        clk = 1'b0;
  logic        areset;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        start_o, ready_i;
  logic [3:0]  res_i, state_i;

  int checks = 0;
  int errors = 0;
  logic [1:0]  bq[$];
  logic [31:0] rq[$];
  // Reference model of the register file
  logic       m_ctrl, m_done, rdy;
  logic [3:0] m_result;

  always #5 clk = ~clk;

  svm_axil_regs dut (
    .s_axi_aclk(clk), .s_axi_areset(areset),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .start_o(start_o), .ready_i(ready_i), .res_i(res_i), .state_i(state_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Write with independent AW/W launch delays; checks latency, bresp, start_o
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input bit count_pulses);
    bit aw_done = 1'b0, w_done = 1'b0, hs_aw, hs_w;
    int lat, pulses;
    logic [1:0] er;
    awaddr = addr; wdata = data; wstrb = strb;
    for (int c = 0; c < 40 && !(aw_done && w_done); c++) begin
      awvalid = !aw_done && (c >= aw_dly);
      wvalid  = !w_done && (c >= w_dly);
      if (aw_done && !w_done) chk("awready_pending", 32'(awready), 32'd0);
      if (w_done && !aw_done) chk("wready_pending", 32'(wready), 32'd0);
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      tick;
      if (hs_aw) aw_done = 1'b1;
      if (hs_w)  w_done  = 1'b1;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) begin
      chk("write_handshake_timeout", 32'd0, 32'd1);
      return;
    end
    if (addr[3:2] == 2'd0) begin
      er = 2'b00;
      if (strb[0]) m_ctrl = data[0];
    end else begin
      er = 2'b10;
    end
    bq.push_back(er);
    lat = 0;
    while (!bvalid && lat < 20) begin
      tick;
      lat++;
    end
    chk("bvalid_latency", 32'(lat), 32'd1);
    if (bvalid) begin
      chk("bresp", 32'(bresp), 32'(bq.pop_front()));
      chk("start_o", 32'(start_o), 32'(m_ctrl));
    end else begin
      chk("bvalid_timeout", 32'd0, 32'd1);
    end
    if (count_pulses) begin
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
        if (bvalid) pulses++;
        tick;
      end
      chk("bvalid_pulses", 32'(pulses), 32'd1);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] addr);
    case (addr[3:2])
      2'd0:    return {31'd0, m_ctrl};
      2'd1:    return {30'd0, m_done, rdy};
      2'd2:    return {28'd0, m_result};
      default: return {28'd0, state_i};
    endcase
  endfunction

  task automatic wait_arready;
    for (int c = 0; c < 20 && !arready; c++) tick;
  endtask

  // Read; the expected data is pushed at the accept edge from the model
  task automatic axi_read(input logic [3:0] addr);
    araddr = addr;
    arvalid = 1'b1;
    wait_arready;
    if (!arready) begin
      arvalid = 1'b0;
      chk("arready_timeout", 32'd0, 32'd1);
      return;
    end
    rq.push_back(model_read(addr));
    tick;
    arvalid = 1'b0;
    if (addr[3:2] == 2'd2) m_done = 1'b0;
    chk("rvalid_latency", 32'(rvalid), 32'd1);
    if (rvalid) begin
      chk("rdata", rdata, rq.pop_front());
      chk("rresp", 32'(rresp), 32'd0);
    end
  endtask

  task automatic set_ready(input logic v, input logic [3:0] r);
    if (v && !rdy) begin
      m_result = r;
      m_done = 1'b1;
    end
    ready_i = v; res_i = r; rdy = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy;
    logic [31:0] rd_hold;
    areset = 1'b1; awaddr = 4'd0; araddr = 4'd0; awprot = 3'd0; arprot = 3'd0;
    awvalid = 1'b0; wvalid = 1'b0; wdata = 32'd0; wstrb = 4'd0; bready = 1'b1;
    arvalid = 1'b0; rready = 1'b1; ready_i = 1'b0; res_i = 4'd0; state_i = 4'h5;
    m_ctrl = 1'b0; m_done = 1'b0; m_result = 4'd0; rdy = 1'b0;
    repeat (3) tick;
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_start", 32'(start_o), 32'd0);
    areset = 1'b0;
    tick;
    chk("post_rst_ready", {29'd0, awready, wready, arready}, 32'd7);

    // Start bit set and cleared, AW/W together
    axi_write(4'h0, 32'h1, 4'hF, 0, 0, 1'b1);
    axi_read(4'h0);
    axi_write(4'h0, 32'h0, 4'hF, 0, 0, 1'b1);
    // AW leads W by 3 cycles, then W leads AW by 3 cycles
    axi_write(4'h0, 32'h1, 4'hF, 0, 3, 1'b1);
    axi_write(4'h0, 32'h0, 4'hF, 3, 0, 1'b1);
    axi_read(4'h0);

    // Result latch and sticky done
    set_ready(1'b1, 4'd7);
    tick;
    axi_read(4'h4);
    axi_read(4'h8);
    axi_read(4'h4);
    set_ready(1'b0, 4'd0);
    tick;

    // Read-only writes and empty strobes
    axi_write(4'h8, 32'hFFFF_FFFF, 4'hF, 0, 0, 1'b1);
    axi_read(4'h8);
    axi_write(4'hC, 32'hFFFF_FFFF, 4'hF, 1, 0, 1'b1);
    axi_write(4'h0, 32'h1, 4'h0, 0, 0, 1'b1);
    axi_read(4'h0);
    axi_read(4'hE);

    // ready_i rises in the cycle a RESULT read is accepted
    araddr = 4'h8;
    arvalid = 1'b1;
    wait_arready;
    rq.push_back(model_read(4'h8));
    ready_i = 1'b1; res_i = 4'd4;
    tick;
    arvalid = 1'b0;
    m_result = 4'd4; m_done = 1'b1; rdy = 1'b1;
    chk("race_rvalid", 32'(rvalid), 32'd1);
    chk("race_rdata_old", rdata, rq.pop_front());
    axi_read(4'h4);
    axi_read(4'h8);
    axi_read(4'h4);
    set_ready(1'b0, 4'd0);
    tick;

    // Back-pressure: responses held stable, readies low, then reset aborts
    state_i = 4'hA;
    bready = 1'b0; rready = 1'b0;
    axi_write(4'h0, 32'h1, 4'hF, 0, 0, 1'b0);
    axi_read(4'hC);
    rd_hold = {28'd0, state_i};
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("hold_bvalid", 32'(bvalid), 32'd1);
      chk("hold_bresp", 32'(bresp), 32'd0);
      chk("hold_rvalid", 32'(rvalid), 32'd1);
      chk("hold_rdata", rdata, rd_hold);
      chk("hold_readies", {29'd0, awready, wready, arready}, 32'd0);
    end
    areset = 1'b1;
    tick;
    m_ctrl = 1'b0; m_done = 1'b0; m_result = 4'd0;
    chk("abort_outputs", {24'd0, bvalid, rvalid, awready, wready, arready, start_o, bresp},
        32'd0);
    chk("abort_rdata", rdata, 32'd0);
    areset = 1'b0; bready = 1'b1; rready = 1'b1;
    tick;
    chk("release_ready", {29'd0, awready, wready, arready}, 32'd7);
    busy = 0;
    for (int i = 0; i < 5; i++) begin
      if (bvalid || rvalid) busy++;
      tick;
    end
    chk("no_stale_response", 32'(busy), 32'd0);
    axi_read(4'h0);
    axi_read(4'h8);
    axi_read(4'h4);
    chk("bq_empty", 32'(bq.size()), 32'd0);
    chk("rq_empty", 32'(rq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
